cplx_mag_calc: RTL and testbench

CPLX_MAG_CALC -- requirements
Module: cplx_mag_calc

---
 rtl/cplx_mag_calc.sv | 175 +++++++++++++++++
 tb/tb_cplx_mag_calc.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/cplx_mag_calc.sv
// Three-stage complex magnitude pipeline: exact |z|^2 or max+min/2 estimate, per-frame mode.
// Optional bin index on m_axis_tuser when CMAG_BIN_IDX_EN is defined.
module cplx_mag_calc #(
    parameter int DATA_W = 16,
    parameter int BIN_W  = 10,
    localparam int OUT_W = 2*DATA_W+1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [2*DATA_W-1:0]   s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic                  mode,
    output logic [OUT_W-1:0]      m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast
`ifdef CMAG_BIN_IDX_EN
    ,
    output logic [BIN_W-1:0]      m_axis_tuser
`endif
);
    localparam int SQ_W = 2*DATA_W;

    function automatic logic [DATA_W-1:0] abs_u(input logic signed [DATA_W-1:0] x);
        logic [DATA_W-1:0] ux;
        ux = x;
        return x[DATA_W-1] ? (~ux + DATA_W'(1)) : ux;
    endfunction

    function automatic logic [SQ_W-1:0] sq_u(input logic [DATA_W-1:0] a);
        return {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, a};
    endfunction

    function automatic logic [OUT_W-1:0] add_u(input logic [SQ_W-1:0] a, input logic [SQ_W-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    logic                     vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
    logic                     last_p1_q, last_p1_d, last_p2_q, last_p2_d, last_p3_q, last_p3_d;
    logic                     mode_p1_q, mode_p1_d;
    logic [DATA_W-1:0]        re_abs_p1_q, re_abs_p1_d, im_abs_p1_q, im_abs_p1_d;
    logic [SQ_W-1:0]          hi_p2_q, hi_p2_d, lo_p2_q, lo_p2_d;
    logic [OUT_W-1:0]         sum_p3_q, sum_p3_d;
    logic                     first_q, first_d, fmode_q, fmode_d;
    logic                     ce, acc, beat_mode;
    logic [DATA_W-1:0]        mx, mn;

    assign ce            = !vld_p3_q || m_axis_tready;
    assign s_axis_tready = ce;
    assign acc           = s_axis_tvalid && ce;
    // The first beat of a frame uses the live mode input; later beats use the latched one.
    assign beat_mode     = first_q ? mode : fmode_q;

    assign m_axis_tdata  = sum_p3_q;
    assign m_axis_tvalid = vld_p3_q;
    assign m_axis_tlast  = last_p3_q;

`ifdef CMAG_BIN_IDX_EN
    logic [BIN_W-1:0] cnt_q, cnt_d;
    logic [BIN_W-1:0] bin_p1_q, bin_p1_d, bin_p2_q, bin_p2_d, bin_p3_q, bin_p3_d;
    assign m_axis_tuser = bin_p3_q;

    always_comb begin
        cnt_d    = cnt_q;
        bin_p1_d = bin_p1_q;
        bin_p2_d = bin_p2_q;
        bin_p3_d = bin_p3_q;
        if (acc) begin
            cnt_d = s_axis_tlast ? '0 : cnt_q + BIN_W'(1);
        end
        if (ce) begin
            bin_p1_d = cnt_q;
            bin_p2_d = bin_p1_q;
            bin_p3_d = bin_p2_q;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
        bin_p1_q <= bin_p1_d;
        bin_p2_q <= bin_p2_d;
        bin_p3_q <= bin_p3_d;
    end
`else
    logic unused_bin_w;
    assign unused_bin_w = (BIN_W > 0);
`endif

    always_comb begin
        vld_p1_d    = vld_p1_q;
        vld_p2_d    = vld_p2_q;
        vld_p3_d    = vld_p3_q;
        last_p1_d   = last_p1_q;
        last_p2_d   = last_p2_q;
        last_p3_d   = last_p3_q;
        mode_p1_d   = mode_p1_q;
        re_abs_p1_d = re_abs_p1_q;
        im_abs_p1_d = im_abs_p1_q;
        hi_p2_d     = hi_p2_q;
        lo_p2_d     = lo_p2_q;
        sum_p3_d    = sum_p3_q;
        first_d     = first_q;
        fmode_d     = fmode_q;
        mx          = (re_abs_p1_q >= im_abs_p1_q) ? re_abs_p1_q : im_abs_p1_q;
        mn          = (re_abs_p1_q >= im_abs_p1_q) ? im_abs_p1_q : re_abs_p1_q;

        if (acc) begin
            first_d = s_axis_tlast;
            if (first_q) begin
                fmode_d = mode;
            end
        end

        if (ce) begin
            // ---- S1: operand magnitudes ----
            vld_p1_d    = s_axis_tvalid;
            last_p1_d   = s_axis_tlast;
            mode_p1_d   = beat_mode;
            re_abs_p1_d = abs_u(s_axis_tdata[DATA_W-1:0]);
            im_abs_p1_d = abs_u(s_axis_tdata[2*DATA_W-1:DATA_W]);
            // ---- S2: squares, or max and half-min, so S3 is a plain add in both modes ----
            vld_p2_d    = vld_p1_q;
            last_p2_d   = last_p1_q;
            if (mode_p1_q) begin
                hi_p2_d = {{DATA_W{1'b0}}, mx};
                lo_p2_d = {{DATA_W{1'b0}}, mn >> 1};
            end else begin
                hi_p2_d = sq_u(re_abs_p1_q);
                lo_p2_d = sq_u(im_abs_p1_q);
            end
            // ---- S3: sum drives the output port ----
            vld_p3_d    = vld_p2_q;
            last_p3_d   = last_p2_q;
            sum_p3_d    = add_u(hi_p2_q, lo_p2_q);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
            last_p1_q <= 1'b0;
            last_p2_q <= 1'b0;
            last_p3_q <= 1'b0;
            sum_p3_q  <= '0;
            first_q   <= 1'b1;
            fmode_q   <= 1'b0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            vld_p3_q  <= vld_p3_d;
            last_p1_q <= last_p1_d;
            last_p2_q <= last_p2_d;
            last_p3_q <= last_p3_d;
            sum_p3_q  <= sum_p3_d;
            first_q   <= first_d;
            fmode_q   <= fmode_d;
        end
    end

    always_ff @(posedge aclk) begin
        mode_p1_q   <= mode_p1_d;
        re_abs_p1_q <= re_abs_p1_d;
        im_abs_p1_q <= im_abs_p1_d;
        hi_p2_q     <= hi_p2_d;
        lo_p2_q     <= lo_p2_d;
    end
endmodule

// File: tb/tb_cplx_mag_calc.sv
// Directed self-checking bench for cplx_mag_calc (DATA_W=16); honours CMAG_BIN_IDX_EN.
module tb_cplx_mag_calc;
    localparam int DW = 16;
    localparam int BW = 10;
    localparam int OW = 2*DW+1;

    logic          clk = 1'b0;
    logic          areset;
    logic [2*DW-1:0] s_tdata;
    logic          s_tvalid, s_tready, s_tlast, mode;
    logic [OW-1:0] m_tdata;
    logic          m_tvalid, m_tready, m_tlast;
    logic [BW-1:0] m_tuser;

    cplx_mag_calc #(.DATA_W(DW), .BIN_W(BW)) dut (
        .aclk(clk), .areset(areset),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast), .mode(mode),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast)
`ifdef CMAG_BIN_IDX_EN
        , .m_axis_tuser(m_tuser)
`endif
    );
`ifndef CMAG_BIN_IDX_EN
    assign m_tuser = '0;
`endif

    always #5 clk = ~clk;

    typedef struct { logic signed [15:0] re; logic signed [15:0] im; logic md; logic last; } beat_t;
    typedef struct { logic [63:0] data; logic last; int bin; } res_t;

    beat_t in_q[$];
    res_t  exp_q[$];
    res_t  out_q[$];
    int    n_total = 0;
    int    n_bad   = 0;
    logic  prev_stall = 1'b0;
    logic [OW-1:0] prev_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(output bit acc);
        res_t r;
        #1;
        if (prev_stall) chk("hold_tdata", 64'(m_tdata), 64'(prev_data));
        chk("s_tready_rule", 64'(s_tready), 64'(!(m_tvalid && !m_tready)));
        if (m_tvalid && m_tready) begin
            r.data = 64'(m_tdata);
            r.last = m_tlast;
            r.bin  = int'(m_tuser);
            out_q.push_back(r);
        end
        prev_stall = m_tvalid && !m_tready;
        prev_data  = m_tdata;
        acc = s_tvalid && s_tready;
        @(negedge clk);
    endtask

    task automatic run(input bit rand_rdy, input string tag);
        int idx = 0;
        int cyc = 0;
        bit acc;
        out_q.delete();
        while ((idx < in_q.size() || out_q.size() < exp_q.size()) && cyc < 300) begin
            if (idx < in_q.size()) begin
                s_tvalid = 1'b1;
                s_tdata  = {in_q[idx].im, in_q[idx].re};
                mode     = in_q[idx].md;
                s_tlast  = in_q[idx].last;
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            step(acc);
            if (acc) idx++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        m_tready = 1'b1;
        chk({tag, "_timeout"}, 64'(cyc < 300), 64'(1));
        for (int i = 0; i < 4; i++) step(acc);
        chk({tag, "_count"}, 64'(out_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), out_q[i].data, exp_q[i].data);
            chk($sformatf("%s_last%0d", tag, i), 64'(out_q[i].last), 64'(exp_q[i].last));
`ifdef CMAG_BIN_IDX_EN
            chk($sformatf("%s_bin%0d", tag, i), 64'(out_q[i].bin), 64'(exp_q[i].bin));
`endif
        end
        in_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int sq8[8];
        sq8 = '{2, 8, 18, 32, 50, 72, 98, 128};
        areset = 1'b1; s_tvalid = 1'b0; s_tlast = 1'b0; mode = 1'b0;
        s_tdata = '0; m_tready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_tlast", 64'(m_tlast), 64'(0));
        chk("rst_tdata", 64'(m_tdata), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(1));
        areset = 1'b0;

        // Latency: 3+4j in mode 0, output held under backpressure.
        s_tvalid = 1'b1; s_tdata = {16'sd4, 16'sd3}; mode = 1'b0; s_tlast = 1'b1;
        #1 chk("lat_accept", 64'(s_tready), 64'(1));
        @(negedge clk); s_tvalid = 1'b0; s_tlast = 1'b0;
        chk("lat_c1", 64'(m_tvalid), 64'(0));
        @(negedge clk); chk("lat_c2", 64'(m_tvalid), 64'(0));
        @(negedge clk); chk("lat_c3", 64'(m_tvalid), 64'(1));
        chk("lat_data", 64'(m_tdata), 64'd25);
        chk("lat_last", 64'(m_tlast), 64'(1));
        @(negedge clk); #1;
        chk("stall_tvalid", 64'(m_tvalid), 64'(1));
        chk("stall_data", 64'(m_tdata), 64'd25);
        chk("stall_s_tready", 64'(s_tready), 64'(0));
        m_tready = 1'b1;
        @(negedge clk); chk("drain_tvalid", 64'(m_tvalid), 64'(0));

        // Corner magnitudes, one-beat frames.
        in_q.push_back('{-16'sd32768, -16'sd32768, 1'b0, 1'b1}); exp_q.push_back('{64'h8000_0000, 1'b1, 0});
        in_q.push_back('{16'sd3, -16'sd4, 1'b1, 1'b1});          exp_q.push_back('{64'd5, 1'b1, 0});
        in_q.push_back('{-16'sd32768, 16'sd0, 1'b1, 1'b1});      exp_q.push_back('{64'd32768, 1'b1, 0});
        run(1'b0, "corner");

        // Eight beats k+kj with random backpressure.
        for (int k = 1; k <= 8; k++) begin
            in_q.push_back('{16'(k), 16'(k), 1'b0, k == 8});
            exp_q.push_back('{64'(sq8[k-1]), k == 8, k-1});
        end
        run(1'b1, "bp");

        // Mode change mid-frame applies only from the next frame.
        in_q.push_back('{16'sd3, 16'sd4, 1'b0, 1'b0}); exp_q.push_back('{64'd25, 1'b0, 0});
        in_q.push_back('{16'sd3, 16'sd4, 1'b1, 1'b0}); exp_q.push_back('{64'd25, 1'b0, 1});
        in_q.push_back('{16'sd3, 16'sd4, 1'b1, 1'b0}); exp_q.push_back('{64'd25, 1'b0, 2});
        in_q.push_back('{16'sd3, 16'sd4, 1'b1, 1'b1}); exp_q.push_back('{64'd25, 1'b1, 3});
        in_q.push_back('{16'sd3, 16'sd4, 1'b1, 1'b1}); exp_q.push_back('{64'd5, 1'b1, 0});
        in_q.push_back('{16'sd6, 16'sd8, 1'b1, 1'b0}); exp_q.push_back('{64'd11, 1'b0, 0});
        in_q.push_back('{16'sd6, 16'sd8, 1'b0, 1'b1}); exp_q.push_back('{64'd11, 1'b1, 1});
        run(1'b0, "frame");

        // Reset with three mode-1 beats in flight, mid-frame.
        m_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_tvalid = 1'b1; s_tdata = {16'sd0, 16'(k+1)}; mode = 1'b1; s_tlast = 1'b0;
            #1 chk("mid_accept", 64'(s_tready), 64'(1));
            @(negedge clk);
        end
        s_tvalid = 1'b0; mode = 1'b0;
        #1 chk("mid_full", 64'(m_tvalid), 64'(1));
        areset = 1'b1;
        @(negedge clk); #1;
        chk("mid_rst_tvalid", 64'(m_tvalid), 64'(0));
        chk("mid_rst_s_tready", 64'(s_tready), 64'(1));
        areset = 1'b0;
        @(negedge clk);
        in_q.push_back('{16'sd3, 16'sd4, 1'b0, 1'b1}); exp_q.push_back('{64'd25, 1'b1, 0});
        run(1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
